// File: rtl/manchester_rx.sv
// Oversampling Manchester receiver: synchronizes the line, locks onto mid-bit
// transitions and assembles LSB-first words with a one-cycle valid pulse.
module manchester_rx #(
    parameter int OVS   = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err
);

    // state | meaning
    // HUNT  | line idle, waiting for the rising mid-bit edge of the start bit
    // RUN   | decoding bits; cnt measures time since the last mid-bit edge

    localparam int CNT_MAX = 5 * OVS / 4;
    localparam int WIN_LO  = 3 * OVS / 4;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(WIDTH);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic             sync1;
    logic             line_s;
    logic             line_d;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic             edge_det;
    logic             rise;
    logic             in_window;
    logic [WIDTH-1:0] shift_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            line_s <= 1'b0;
            line_d <= 1'b0;
        end else begin
            sync1  <= line_in;
            line_s <= sync1;
            line_d <= line_s;
        end
    end

    assign edge_det   = line_s ^ line_d;
    assign rise       = edge_det & line_s;
    assign in_window  = (cnt >= CW'(WIN_LO));
    // The post-transition level of a mid-bit edge is the decoded bit value.
    assign shift_next = {line_s, shift[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                HUNT: begin
                    if (rise) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    // An edge at the saturation point still counts as a bit.
                    if (edge_det && in_window) begin
                        shift <= shift_next;
                        cnt   <= '0;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            data_out   <= shift_next;
                            data_valid <= 1'b1;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else if (cnt == CW'(CNT_MAX)) begin
                        state <= HUNT;
                        busy  <= 1'b0;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_rx.sv
// Self-checking bench for manchester_rx: drives Manchester frames and compares
// received words and frame errors with a bit-list reference model.
module tb_manchester_rx;

    localparam int OVS   = 16;
    localparam int WIDTH = 8;

    typedef bit bitq_t[$];
    typedef logic [WIDTH-1:0] wordq_t[$];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             line_in = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    manchester_rx #(.OVS(OVS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (line_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [WIDTH-1:0] dv_q[$];
    int               dv_cyc[$];
    int               fe_cnt = 0;
    int               busy_fall_cyc = 0;
    int               busy_hi_cnt = 0;
    logic             busy_prev = 1'b0;
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_q.push_back(data_out);
            dv_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        if (busy === 1'b1) busy_hi_cnt++;
        busy_prev = busy;
    end

    logic [WIDTH-1:0] exp_last = '0;
    int               last_mid = 0;

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        dv_q.delete();
        dv_cyc.delete();
        fe_cnt      = 0;
        busy_hi_cnt = 0;
    endtask

    task automatic drive_bit(input bit b, input int h1, input int h2);
        line_in = ~b;
        hold(h1);
        line_in = b;
        last_mid = cyc;
        hold(h2);
    endtask

    // Start bit, payload bits, then idle low long enough for the frame to time out.
    task automatic send_bits(input bitq_t bits, input bit jitter);
        int h1, h2;
        drive_bit(1'b1, OVS / 2, OVS / 2);
        foreach (bits[i]) begin
            h1 = jitter ? int'($urandom_range(OVS / 2 + 1, OVS / 2 - 1)) : OVS / 2;
            h2 = jitter ? int'($urandom_range(OVS / 2 + 1, OVS / 2 - 1)) : OVS / 2;
            drive_bit(bits[i], h1, h2);
        end
        line_in = 1'b0;
        hold(3 * OVS);
    endtask

    function automatic bitq_t word_bits(input logic [31:0] w, input int n);
        bitq_t q;
        for (int i = 0; i < n; i++) q.push_back(w[i]);
        return q;
    endfunction

    // Reference: every complete group of WIDTH bits is a word, any remainder is an error.
    function automatic wordq_t model_words(input bitq_t bits);
        wordq_t           q;
        logic [WIDTH-1:0] w;
        for (int k = 0; k + WIDTH <= bits.size(); k += WIDTH) begin
            for (int j = 0; j < WIDTH; j++) w[j] = bits[k + j];
            q.push_back(w);
        end
        return q;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #22;
        n_checks++;
        if (data_out !== '0 || data_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data_out=%0h dv=%b busy=%b fe=%b, expected all zero",
                     data_out, data_valid, busy, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        exp_last = '0;
    endtask

    task automatic test_single_a5();
        clear_mon();
        line_in = 1'b0;
        hold(100);
        send_bits(word_bits(32'hA5, 8), 1'b0);
        n_checks++;
        if (dv_q.size() !== 1) begin
            n_fail++;
            $display("FAIL a5_count: got %0d pulses, expected 1", dv_q.size());
        end else begin
            n_checks++;
            if (dv_q[0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL a5_value: got %0h expected a5", dv_q[0]);
            end
            n_checks++;
            if (dv_cyc[0] - last_mid < 2 || dv_cyc[0] - last_mid > 5) begin
                n_fail++;
                $display("FAIL a5_latency: got %0d cycles expected 2..5", dv_cyc[0] - last_mid);
            end
        end
        n_checks++;
        if (fe_cnt !== 0) begin
            n_fail++;
            $display("FAIL a5_frame_err: got %0d expected 0", fe_cnt);
        end
        n_checks++;
        if (busy_fall_cyc - last_mid < 20 || busy_fall_cyc - last_mid > 25) begin
            n_fail++;
            $display("FAIL a5_busy_drop: got %0d cycles after last mid-bit edge, expected 20..25",
                     busy_fall_cyc - last_mid);
        end
        exp_last = 8'hA5;
    endtask

    task automatic test_back_to_back();
        wordq_t exp_q;
        bitq_t  bits;
        bits  = word_bits(32'hDEADBEEF, 32);
        exp_q = model_words(bits);
        clear_mon();
        send_bits(bits, 1'b0);
        n_checks++;
        if (dv_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected %0d", dv_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (dv_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_word%0d: got %0h expected %0h", i, dv_q[i], exp_q[i]);
                end
                if (i > 0) begin
                    n_checks++;
                    if (dv_cyc[i] - dv_cyc[i-1] != WIDTH * OVS) begin
                        n_fail++;
                        $display("FAIL b2b_spacing%0d: got %0d expected %0d",
                                 i, dv_cyc[i] - dv_cyc[i-1], WIDTH * OVS);
                    end
                end
            end
            exp_last = exp_q[exp_q.size() - 1];
        end
        n_checks++;
        if (fe_cnt !== 0) begin
            n_fail++;
            $display("FAIL b2b_frame_err: got %0d expected 0", fe_cnt);
        end
    endtask

    task automatic test_partial();
        bitq_t bits;
        bits = '{1'b1, 1'b0, 1'b1};
        clear_mon();
        send_bits(bits, 1'b0);
        n_checks++;
        if (fe_cnt !== 1) begin
            n_fail++;
            $display("FAIL partial_frame_err: got %0d pulses expected 1", fe_cnt);
        end
        n_checks++;
        if (dv_q.size() !== 0) begin
            n_fail++;
            $display("FAIL partial_no_valid: got %0d pulses expected 0", dv_q.size());
        end
        n_checks++;
        if (data_out !== exp_last) begin
            n_fail++;
            $display("FAIL partial_data_hold: got %0h expected %0h", data_out, exp_last);
        end
    endtask

    task automatic test_jitter();
        for (int r = 0; r < 4; r++) begin
            clear_mon();
            send_bits(word_bits(32'h3C, 8), 1'b1);
            n_checks++;
            if (dv_q.size() !== 1 || fe_cnt !== 0) begin
                n_fail++;
                $display("FAIL jitter_count%0d: got %0d pulses %0d errors expected 1 and 0",
                         r, dv_q.size(), fe_cnt);
            end
            n_checks++;
            if (data_out !== 8'h3C) begin
                n_fail++;
                $display("FAIL jitter_value%0d: got %0h expected 3c", r, data_out);
            end
        end
        exp_last = 8'h3C;
    endtask

    task automatic test_reset_midframe();
        clear_mon();
        drive_bit(1'b1, OVS / 2, OVS / 2);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, OVS / 2, OVS / 2);
        line_in = 1'b0;
        hold(OVS / 2);
        line_in = 1'b1;
        hold(3);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== '0 || data_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got data_out=%0h dv=%b busy=%b fe=%b, expected all zero",
                     data_out, data_valid, busy, frame_err);
        end
        line_in = 1'b0;
        hold(5);
        rst_n = 1'b1;
        exp_last = '0;
        hold(30);
        n_checks++;
        if (dv_q.size() !== 0 || fe_cnt !== 0) begin
            n_fail++;
            $display("FAIL midreset_aborted: got %0d pulses %0d errors expected 0 and 0",
                     dv_q.size(), fe_cnt);
        end
        send_bits(word_bits(32'h81, 8), 1'b0);
        n_checks++;
        if (dv_q.size() !== 1) begin
            n_fail++;
            $display("FAIL midreset_next_count: got %0d expected 1", dv_q.size());
        end else begin
            n_checks++;
            if (dv_q[0] !== 8'h81) begin
                n_fail++;
                $display("FAIL midreset_next_value: got %0h expected 81", dv_q[0]);
            end
        end
        exp_last = 8'h81;
    endtask

    task automatic test_random_frames();
        bitq_t  bits;
        wordq_t exp_q;
        int     n;
        bit     exp_err;
        for (int f = 0; f < 8; f++) begin
            bits.delete();
            n = int'($urandom_range(3 * WIDTH + 3, 1));
            for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(1, 0)));
            exp_q   = model_words(bits);
            exp_err = (n % WIDTH) != 0;
            clear_mon();
            send_bits(bits, f[0]);
            if (exp_q.size() > 0) exp_last = exp_q[exp_q.size() - 1];
            n_checks++;
            if (dv_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d expected %0d (nbits %0d)",
                         f, dv_q.size(), exp_q.size(), n);
            end else begin
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (dv_q[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_word%0d: got %0h expected %0h", f, i, dv_q[i], exp_q[i]);
                    end
                end
            end
            n_checks++;
            if (fe_cnt !== int'(exp_err)) begin
                n_fail++;
                $display("FAIL rand%0d_frame_err: got %0d expected %0d", f, fe_cnt, exp_err);
            end
            n_checks++;
            if (data_out !== exp_last) begin
                n_fail++;
                $display("FAIL rand%0d_data_out: got %0h expected %0h", f, data_out, exp_last);
            end
        end
    endtask

    task automatic test_idle_long();
        clear_mon();
        line_in = 1'b0;
        hold(10000);
        n_checks++;
        if (busy_hi_cnt !== 0 || dv_q.size() !== 0 || fe_cnt !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got busy cycles %0d pulses %0d errors %0d expected 0 0 0",
                     busy_hi_cnt, dv_q.size(), fe_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_partial();
        test_jitter();
        test_reset_midframe();
        test_random_frames();
        test_idle_long();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
